// File: rtl/memory_bus_pkg.sv
// Shared MemoryBus packet types and arbiter state encoding.
package memory_bus_pkg;

  localparam int BUS_ID_W = 3;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;

  typedef enum logic [1:0] {
    read_data     = 2'd0,
    write_data    = 2'd1,
    read_response = 2'd2
  } BusPacketType;

  typedef logic [BUS_ID_W-1:0] BusID;
  typedef logic [ADDR_W-1:0]   memory_address_t;
  typedef logic [DATA_W-1:0]   bus_packet_payload_t;

  typedef struct packed {
    BusPacketType        packet_type;
    BusID                source;
    memory_address_t     address;
    bus_packet_payload_t payload;
  } BusPacket;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_OFFER = 1'b1
  } arb_state_t;

  function automatic logic is_read_req(input BusPacket p);
    return p.packet_type == read_data;
  endfunction

endpackage

// File: rtl/memory_bus_arbiter_rr_picker.sv
// Round-robin select: first asserted request at or after ptr, wrapping.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   index
);

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // scan from ptr upward; the first hit wins and later hits are ignored
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[wrap_add(ptr, k)]) begin
        found = 1'b1;
        index = wrap_add(ptr, k);
      end
    end
  end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter for the MemoryBus request slot, with response routing
// by source BusID and a per-requester cap on reads in flight.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ARB_IDLE  | pick an eligible requester, pulse its req_ready, latch packet
//   ARB_OFFER | bus_req_valid high, packet held until bus_req_ready
module memory_bus_arbiter
  import memory_bus_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_OUTST = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  BusPacket [NUM_REQ-1:0] req_pkt,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 bus_req_valid,
  output BusPacket             bus_req_pkt,
  input  logic                 bus_req_ready,
  input  logic                 bus_rsp_valid,
  input  BusPacket             bus_rsp_pkt,
  output logic                 bus_rsp_ready,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output BusPacket             rsp_pkt,
  input  logic [NUM_REQ-1:0]   rsp_ready
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    winner_q;
  logic [NUM_REQ-1:0]  eligible;
  logic                pick_found;
  logic [IDX_W-1:0]    pick_idx;
  logic                grant;
  logic                bus_xfer;
  BusPacket            grant_pkt;

  logic [CNT_W-1:0]    outst_cnt [NUM_REQ];
  logic [NUM_REQ-1:0]  cnt_inc;
  logic [NUM_REQ-1:0]  cnt_dec;

  BusID                rsp_src;
  logic [IDX_W-1:0]    rsp_idx;
  logic                rsp_routed;
  logic                rsp_xfer;

  // a requester at its read cap may still post writes
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] && !(is_read_req(req_pkt[i]) && outst_cnt[i] == CNT_MAX);
    end
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req   (eligible),
    .ptr   (rr_ptr),
    .found (pick_found),
    .index (pick_idx)
  );

  // source is overwritten so responses find their way back to the winner
  always_comb begin
    grant_pkt        = req_pkt[pick_idx];
    grant_pkt.source = BusID'(pick_idx);
  end

  // next-state and handshake decode
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    grant     = 1'b0;
    bus_xfer  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant               = 1'b1;
          req_ready[pick_idx] = 1'b1;
          state_d             = ARB_OFFER;
        end
      end
      ARB_OFFER: begin
        if (bus_req_ready) begin
          bus_xfer = 1'b1;
          state_d  = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // bus_req_valid decodes the state register so reset drops it at once
  assign bus_req_valid = (state_q == ARB_OFFER);

  // state register, latched packet and round-robin pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ARB_IDLE;
      rr_ptr      <= '0;
      winner_q    <= '0;
      bus_req_pkt <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        winner_q    <= pick_idx;
        bus_req_pkt <= grant_pkt;
      end
      if (bus_xfer) begin
        rr_ptr <= (winner_q == LAST_IDX) ? '0 : winner_q + 1'b1;
      end
    end
  end

  assign rsp_src    = bus_rsp_pkt.source;
  assign rsp_idx    = rsp_src[IDX_W-1:0];
  assign rsp_routed = bus_rsp_valid
                   && bus_rsp_pkt.packet_type == read_response
                   && 32'(rsp_src) < 32'(NUM_REQ);
  assign rsp_xfer   = rsp_routed && rsp_ready[rsp_idx];
  assign rsp_pkt    = bus_rsp_valid ? bus_rsp_pkt : '0;

  // route a valid response to its owner; anything unroutable is drained
  always_comb begin
    rsp_valid     = '0;
    bus_rsp_ready = 1'b0;
    if (bus_rsp_valid) begin
      if (rsp_routed) begin
        rsp_valid[rsp_idx] = 1'b1;
        bus_rsp_ready      = rsp_ready[rsp_idx];
      end else begin
        bus_rsp_ready = 1'b1;
      end
    end
  end

  // per-requester increment on read issue and decrement on response taken
  always_comb begin
    cnt_inc = '0;
    cnt_dec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_inc[i] = bus_xfer && winner_q == IDX_W'(i) && is_read_req(bus_req_pkt);
      cnt_dec[i] = rsp_xfer && rsp_idx == IDX_W'(i);
    end
  end

  // saturating counters; a stray response at zero leaves the count alone
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) outst_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (cnt_inc[i] && !cnt_dec[i] && outst_cnt[i] != CNT_MAX) begin
          outst_cnt[i] <= outst_cnt[i] + 1'b1;
        end else if (cnt_dec[i] && !cnt_inc[i] && outst_cnt[i] != '0) begin
          outst_cnt[i] <= outst_cnt[i] - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench for memory_bus_arbiter (NUM_REQ=4, MAX_OUTST=2).
module tb_memory_bus_arbiter;
  import memory_bus_pkg::*;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [3:0]         req_valid;
  BusPacket [3:0]     req_pkt;
  logic [3:0]         req_ready;
  logic               bus_req_valid;
  BusPacket           bus_req_pkt;
  logic               bus_req_ready;
  logic               bus_rsp_valid;
  BusPacket           bus_rsp_pkt;
  logic               bus_rsp_ready;
  logic [3:0]         rsp_valid;
  BusPacket           rsp_pkt;
  logic [3:0]         rsp_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  memory_bus_arbiter #(.NUM_REQ(4), .MAX_OUTST(2)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_pkt       (req_pkt),
    .req_ready     (req_ready),
    .bus_req_valid (bus_req_valid),
    .bus_req_pkt   (bus_req_pkt),
    .bus_req_ready (bus_req_ready),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rsp_pkt   (bus_rsp_pkt),
    .bus_rsp_ready (bus_rsp_ready),
    .rsp_valid     (rsp_valid),
    .rsp_pkt       (rsp_pkt),
    .rsp_ready     (rsp_ready)
  );

  // counters packed as {c3,c2,c1,c0}, two bits each
  wire [7:0] cnt_all = {dut.outst_cnt[3], dut.outst_cnt[2], dut.outst_cnt[1], dut.outst_cnt[0]};

  function automatic BusPacket mk(input BusPacketType t, input BusID s,
                                  input memory_address_t a, input bus_packet_payload_t d);
    BusPacket p;
    p.packet_type = t;
    p.source      = s;
    p.address     = a;
    p.payload     = d;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n       = 1'b0;
    req_valid     = '0;
    req_pkt       = '0;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_rsp_pkt   = '0;
    rsp_ready     = '0;
    #12;
    chk("rst_bus_req_valid", bus_req_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_bus_req_pkt", bus_req_pkt, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_bus_rsp_ready", bus_rsp_ready, 0);
    chk("rst_counters", cnt_all, 0);
    chk("rst_rr_ptr", dut.rr_ptr, 0);
    reset_n = 1'b1;
    step;

    // all four present writes, bus always ready: 0,1,2,3,0,1,2,3
    for (int i = 0; i < 4; i++) req_pkt[i] = mk(write_data, 3'd0, 32'h1000 + 32'(i), 32'(i));
    req_valid     = 4'hF;
    bus_req_ready = 1'b1;
    for (int g = 0; g < 8; g++) begin
      #1;
      chk("rr_grant", req_ready, 4'b1 << (g % 4));
      step;
      chk("rr_offer_valid", bus_req_valid, 1);
      chk("rr_offer_src", bus_req_pkt.source, g % 4);
      chk("rr_offer_no_ready", req_ready, 0);
      step;
    end
    req_valid = '0;

    // single read from requester 2; source field gets overwritten
    req_pkt[2] = mk(read_data, 3'd5, 32'h100, 32'h0);
    req_valid  = 4'b0100;
    #1;
    chk("t1_req_ready", req_ready, 4'b0100);
    step;
    req_valid = '0;
    chk("t1_bus_valid", bus_req_valid, 1);
    chk("t1_bus_pkt", bus_req_pkt, mk(read_data, 3'd2, 32'h100, 32'h0));
    step;
    chk("t1_bus_idle", bus_req_valid, 0);
    chk("t1_counters", cnt_all, 8'h10);
    chk("t1_rr_ptr", dut.rr_ptr, 3);

    // requester 1 reaches its read cap
    req_pkt[1] = mk(read_data, 3'd1, 32'h200, 32'h0);
    req_valid  = 4'b0010;
    for (int r = 0; r < 2; r++) begin
      #1;
      chk("t3_read_grant", req_ready, 4'b0010);
      step;
      step;
    end
    chk("t3_counters_full", cnt_all, 8'h18);
    req_pkt[3] = mk(write_data, 3'd3, 32'h300, 32'hAA);
    req_valid  = 4'b1010;
    #1;
    chk("t3_other_granted", req_ready, 4'b1000);
    step;
    req_valid = 4'b0010;
    chk("t3_other_src", bus_req_pkt.source, 3);
    step;
    #1;
    chk("t3_stall", req_ready, 0);
    step;
    chk("t3_stall_again", req_ready, 0);
    bus_rsp_valid = 1'b1;
    bus_rsp_pkt   = mk(read_response, 3'd1, 32'h200, 32'hDEAD);
    rsp_ready     = 4'b0010;
    #1;
    chk("t3_rsp_valid", rsp_valid, 4'b0010);
    chk("t3_rsp_ready", bus_rsp_ready, 1);
    chk("t3_still_stalled", req_ready, 0);
    step;
    bus_rsp_valid = 1'b0;
    rsp_ready     = '0;
    #1;
    chk("t3_counters_freed", cnt_all, 8'h14);
    chk("t3_freed_grant", req_ready, 4'b0010);
    req_valid = '0;

    // bus stalls five cycles during an offer
    bus_req_ready = 1'b0;
    req_pkt[3]    = mk(write_data, 3'd0, 32'h340, 32'h1234);
    req_valid     = 4'b1000;
    #1;
    chk("t4_grant", req_ready, 4'b1000);
    step;
    req_pkt[0] = mk(write_data, 3'd0, 32'h40, 32'h55);
    req_valid  = 4'b1001;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t4_hold_valid", bus_req_valid, 1);
      chk("t4_hold_pkt", bus_req_pkt, mk(write_data, 3'd3, 32'h340, 32'h1234));
      chk("t4_hold_no_ready", req_ready, 0);
      step;
    end
    bus_req_ready = 1'b1;
    step;
    #1;
    chk("t4_done_idle", bus_req_valid, 0);
    chk("t4_next_grant", req_ready, 4'b0001);
    req_valid = '0;

    // read from requester 0, then its response waits on rsp_ready
    req_pkt[0] = mk(read_data, 3'd0, 32'h400, 32'h0);
    req_valid  = 4'b0001;
    #1;
    chk("t5_read_grant", req_ready, 4'b0001);
    step;
    req_valid = '0;
    step;
    chk("t5_counters_issue", cnt_all, 8'h15);
    bus_rsp_valid = 1'b1;
    bus_rsp_pkt   = mk(read_response, 3'd0, 32'h400, 32'hBEEF);
    rsp_ready     = '0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t5_rsp_valid", rsp_valid, 4'b0001);
      chk("t5_rsp_blocked", bus_rsp_ready, 0);
      chk("t5_rsp_pkt", rsp_pkt, mk(read_response, 3'd0, 32'h400, 32'hBEEF));
      step;
    end
    chk("t5_counters_wait", cnt_all, 8'h15);
    rsp_ready = 4'b0001;
    #1;
    chk("t5_rsp_taken", bus_rsp_ready, 1);
    step;
    chk("t5_counters_taken", cnt_all, 8'h14);
    bus_rsp_pkt = mk(read_response, 3'd7, 32'h0, 32'h0);
    rsp_ready   = '0;
    #1;
    chk("t5_bad_src_no_valid", rsp_valid, 0);
    chk("t5_bad_src_drain", bus_rsp_ready, 1);
    step;
    chk("t5_bad_src_counters", cnt_all, 8'h14);
    bus_rsp_pkt = mk(write_data, 3'd2, 32'h0, 32'h0);
    #1;
    chk("t5_bad_type_no_valid", rsp_valid, 0);
    chk("t5_bad_type_drain", bus_rsp_ready, 1);
    step;
    chk("t5_bad_type_counters", cnt_all, 8'h14);
    bus_rsp_pkt = mk(read_response, 3'd3, 32'h0, 32'h0);
    rsp_ready   = 4'b1000;
    #1;
    chk("t5_stray_valid", rsp_valid, 4'b1000);
    step;
    chk("t5_no_underflow", cnt_all, 8'h14);
    bus_rsp_valid = 1'b0;
    rsp_ready     = '0;

    // issue and retire on requester 2 in the same cycle
    req_pkt[2] = mk(read_data, 3'd2, 32'h500, 32'h0);
    req_valid  = 4'b0100;
    #1;
    chk("t5_same_grant", req_ready, 4'b0100);
    step;
    req_valid     = '0;
    bus_rsp_valid = 1'b1;
    bus_rsp_pkt   = mk(read_response, 3'd2, 32'h100, 32'h77);
    rsp_ready     = 4'b0100;
    #1;
    chk("t5_same_rsp_ready", bus_rsp_ready, 1);
    step;
    bus_rsp_valid = 1'b0;
    rsp_ready     = '0;
    chk("t5_same_counters", cnt_all, 8'h14);
    chk("t5_same_rr_ptr", dut.rr_ptr, 3);

    // reset in the middle of an offer
    bus_req_ready = 1'b0;
    req_pkt[0]    = mk(write_data, 3'd0, 32'h600, 32'h0);
    req_valid     = 4'b0001;
    #1;
    chk("t6_grant", req_ready, 4'b0001);
    step;
    chk("t6_offer", bus_req_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_drop", bus_req_valid, 0);
    chk("t6_counters", cnt_all, 0);
    chk("t6_rr_ptr", dut.rr_ptr, 0);
    chk("t6_pkt_cleared", bus_req_pkt, 0);
    for (int i = 0; i < 4; i++) req_pkt[i] = mk(write_data, 3'd0, 32'h700 + 32'(i), 32'h0);
    req_valid = 4'hF;
    step;
    reset_n       = 1'b1;
    bus_req_ready = 1'b1;
    #1;
    chk("t6_restart_grant", req_ready, 4'b0001);
    step;
    chk("t6_restart_src", bus_req_pkt.source, 0);
    req_valid = '0;
    step;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
